// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core load/store path vs. DMA/loader port.
// Optional macro ARB_STATS_EN adds a saturating core stall-cycle counter on stall_cycles.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cycles
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  // Arbitration state, kept in one struct so checkers can bind to state_q.
  typedef struct packed {
    owner_e     last_owner;
    logic [3:0] burst_cnt;
  } arb_state_t;

  arb_state_t state_q, state_d;
  logic       core_gnt;
  logic       dma_win;

  // State register; reset leaves DMA as last owner with an exhausted burst
  // so the first contention goes to the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q.last_owner <= OWN_DMA;
      state_q.burst_cnt  <= MAX_BURST_C;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decode: combinational, zero-cycle, suppressed while in reset.
  always_comb begin
    core_gnt = 1'b0;
    dma_win  = 1'b0;
    if (!rst) begin
      if (core_req && dma_req) begin
        if (state_q.last_owner == OWN_DMA && state_q.burst_cnt >= MAX_BURST_C) begin
          core_gnt = 1'b1;
        end else begin
          dma_win = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        dma_win  = dma_req;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (core_gnt) begin
      state_d.last_owner = OWN_CORE;
      state_d.burst_cnt  = 4'd0;
    end else if (dma_win) begin
      if (state_q.last_owner == OWN_DMA) begin
        state_d.burst_cnt = (state_q.burst_cnt >= MAX_BURST_C) ? MAX_BURST_C
                                                               : state_q.burst_cnt + 4'd1;
      end else begin
        state_d.burst_cnt = 4'd1;
      end
      state_d.last_owner = OWN_DMA;
    end else begin
      state_d.burst_cnt = 4'd0;
    end
  end

  // Output steering: the winner owns the memory port; all-zero when idle.
  always_comb begin
    core_stall = core_req & ~core_gnt & ~rst;
    dma_gnt    = dma_win;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_rdata = '0;
    dma_rdata  = '0;
    if (core_gnt) begin
      mem_we     = core_we;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      core_rdata = mem_rdata;
    end else if (dma_win) begin
      mem_we     = dma_we;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
      dma_rdata  = mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (core_stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
